// File: rtl/genius_pkg.sv
// genius_pkg: shared types and constants for the Genius input checker.
//   sym_t     - 2-bit player/sequence symbol
//   state_e   - checker FSM state encoding
//   SYM_*     - symbol constants; SYM_NONE never matches a press
//   rise_to_sym - encodes a one-hot press vector {bt2,bt1,bt0} to a symbol
package genius_pkg;

  typedef logic [1:0] sym_t;

  localparam sym_t SYM_0    = 2'd0;
  localparam sym_t SYM_1    = 2'd1;
  localparam sym_t SYM_2    = 2'd2;
  localparam sym_t SYM_NONE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    CHECK,
    WAIT_RELEASE,
    PASS,
    FAIL
  } state_e;

  // Caller guarantees rise is one-hot.
  function automatic sym_t rise_to_sym(input logic [2:0] rise);
    sym_t s;
    s = SYM_0;
    if (rise[1]) s = SYM_1;
    if (rise[2]) s = SYM_2;
    return s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer + stability counter for one raw button.
//   clk_i   - clock
//   rst_i   - synchronous active-high reset
//   btn_i   - raw asynchronous button (1 = pressed)
//   level_o - debounced level
//   rise_o  - one-cycle pulse on a debounced 0->1 transition
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          prev_q;

  // cnt_q counts consecutive cycles the synchronized input has disagreed
  // with the accepted level; any agreement restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync_q[1];
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~prev_q;

endmodule

// File: rtl/genius_input_checker.sv
// genius_input_checker: debounces three player buttons and checks each press
// against an external sequence store for one round of round_len+1 symbols.
//   clock, reset        - clock, synchronous active-high reset
//   bt0..bt2            - raw buttons, symbols 0..2
//   start, round_len    - begin a round (accepted only in IDLE), last index
//   seq_idx / seq_sym   - sequence store address / combinational symbol
//   press_valid/sym     - one-cycle pulse with the captured symbol
//   busy, pass, fail    - round active; one-cycle result pulses
// Optional: define GENIUS_TIMEOUT_EN to fail after TIMEOUT_CYCLES in WAIT_PRESS.
module genius_input_checker
  import genius_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bt0,
  input  logic       bt1,
  input  logic       bt2,
  input  logic       start,
  input  logic [3:0] round_len,
  output logic [3:0] seq_idx,
  input  logic [1:0] seq_sym,
  output logic       press_valid,
  output logic [1:0] press_sym,
  output logic       busy,
  output logic       pass,
  output logic       fail
);

  logic [2:0] btn_raw, level, rise;
  assign btn_raw = {bt2, bt1, bt0};

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [2:0] (
    .clk_i   (clock),
    .rst_i   (reset),
    .btn_i   (btn_raw),
    .level_o (level),
    .rise_o  (rise)
  );

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] len_q, len_d;
  sym_t       sym_q, sym_d;
  logic       last_q, last_d;
  logic       pv_q, pv_d;
  logic       timed_out;

`ifdef GENIUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  assign timed_out = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    sym_d   = sym_q;
    last_d  = last_q;
    pv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = round_len;
          idx_d   = '0;
          last_d  = 1'b0;
          state_d = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (rise == 3'b000) begin
          if (timed_out) state_d = FAIL;
        end else if ((rise & (rise - 3'd1)) == 3'b000) begin
          sym_d   = rise_to_sym(rise);
          pv_d    = 1'b1;
          state_d = CHECK;
        end else begin
          // Simultaneous presses are ambiguous: fail without reporting one.
          state_d = FAIL;
        end
      end
      CHECK: begin
        if (seq_sym == SYM_NONE || seq_sym != sym_q) begin
          state_d = FAIL;
        end else begin
          last_d  = (idx_q == len_q);
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (level == 3'b000) begin
          if (last_q) begin
            state_d = PASS;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = WAIT_PRESS;
          end
        end
      end
      PASS:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef GENIUS_TIMEOUT_EN
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == WAIT_PRESS) tmo_d = tmo_q + 1'b1;
    if (state_d == WAIT_PRESS && state_q != WAIT_PRESS) tmo_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      sym_q   <= SYM_0;
      last_q  <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      sym_q   <= sym_d;
      last_q  <= last_d;
      pv_q    <= pv_d;
    end
  end

  assign seq_idx     = idx_q;
  assign press_valid = pv_q;
  assign press_sym   = sym_q;
  assign busy        = (state_q == WAIT_PRESS) || (state_q == CHECK) ||
                       (state_q == WAIT_RELEASE);
  assign pass        = (state_q == PASS);
  assign fail        = (state_q == FAIL);

endmodule

// File: tb/tb_genius_input_checker.sv
module tb_genius_input_checker;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] btn;
  logic       start;
  logic [3:0] round_len;
  logic [3:0] seq_idx;
  logic [1:0] seq_sym;
  logic       press_valid;
  logic [1:0] press_sym;
  logic       busy, pass, fail;

  logic [1:0] mem [16];
  always_comb seq_sym = mem[seq_idx];

  genius_input_checker #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
    .clock       (clock),
    .reset       (reset),
    .bt0         (btn[0]),
    .bt1         (btn[1]),
    .bt2         (btn[2]),
    .start       (start),
    .round_len   (round_len),
    .seq_idx     (seq_idx),
    .seq_sym     (seq_sym),
    .press_valid (press_valid),
    .press_sym   (press_sym),
    .busy        (busy),
    .pass        (pass),
    .fail        (fail)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // kind: 0 = press_valid, 1 = pass, 2 = fail
  typedef struct { int kind; int sym; } ev_t;
  ev_t expq[$];

  int total = 0;
  int bad   = 0;
  int npress = 0;
  int last_press_cyc = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input int sym);
    ev_t e;
    e.kind = kind;
    e.sym  = sym;
    expq.push_back(e);
  endtask

  // Called once per negedge: every output pulse must match the queue head.
  task automatic sample();
    int   k;
    ev_t  e;
    if (press_valid || pass || fail) begin
      k = press_valid ? 0 : (pass ? 1 : 2);
      if (press_valid) begin
        npress++;
        last_press_cyc = cyc;
      end
      if (expq.size() == 0) begin
        chk("unexpected_event", k, -1);
      end else begin
        e = expq.pop_front();
        chk("event_kind", k, e.kind);
        if (k == 0) chk("press_sym", int'(press_sym), e.sym);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      sample();
    end
  endtask

  task automatic do_start(input logic [3:0] len);
    round_len = len;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic press_release(input int b);
    btn[b] = 1'b1;
    tick(12);
    btn[b] = 1'b0;
    tick(12);
  endtask

  initial begin
    int c0;
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    reset = 1'b1; btn = '0; start = 1'b0; round_len = '0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // reset state
    chk("rst_busy", int'(busy), 0);
    chk("rst_seq_idx", int'(seq_idx), 0);
    chk("rst_press_valid", int'(press_valid), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_press_sym", int'(press_sym), 0);

    // full pass: 0,1,0
    mem[0] = 2'd0; mem[1] = 2'd1; mem[2] = 2'd0;
    do_start(4'd2);
    chk("pass_busy_on", int'(busy), 1);
    push(0, 0); press_release(0);
    chk("pass_idx1", int'(seq_idx), 1);
    push(0, 1); press_release(1);
    chk("pass_idx2", int'(seq_idx), 2);
    push(0, 0); push(1, 0); press_release(0);
    chk("pass_busy_off", int'(busy), 0);
    chk("pass_q_empty", expq.size(), 0);

    // mismatch: expect 1, press 2
    mem[0] = 2'd1;
    do_start(4'd3);
    push(0, 2); push(2, 0);
    press_release(2);
    chk("mis_busy_off", int'(busy), 0);
    chk("mis_seq_idx", int'(seq_idx), 0);
    chk("mis_q_empty", expq.size(), 0);

    // bounce on bt1: only the final stable level yields one press
    mem[0] = 2'd1;
    do_start(4'd0);
    c0 = npress;
    for (int i = 0; i < 10; i++) begin
      btn[1] = ~btn[1];
      tick(2);
    end
    push(0, 1); push(1, 0);
    btn[1] = 1'b1;
    c0 = c0 + 0;
    begin
      int t_set;
      t_set = cyc;
      tick(12);
      // 2 synchronizer flops + 4 stable cycles + 1 capture register
      chk("bounce_latency", last_press_cyc - t_set, 7);
    end
    btn[1] = 1'b0;
    tick(12);
    chk("bounce_one_press", npress - c0, 1);
    chk("bounce_q_empty", expq.size(), 0);

    // simultaneous bt0 + bt2
    c0 = npress;
    do_start(4'd1);
    push(2, 0);
    btn[0] = 1'b1; btn[2] = 1'b1;
    tick(12);
    btn = '0;
    tick(12);
    chk("simul_no_press", npress - c0, 0);
    chk("simul_busy_off", int'(busy), 0);
    chk("simul_q_empty", expq.size(), 0);

    // timeout / indefinite wait
    mem[0] = 2'b11;
    do_start(4'd0);
`ifdef GENIUS_TIMEOUT_EN
    push(2, 0);
    tick(90);
    chk("tmo_busy_before", int'(busy), 1);
    tick(15);
    chk("tmo_busy_after", int'(busy), 0);
`else
    tick(1000);
    chk("notmo_busy", int'(busy), 1);
    // SYM_NONE in the store never matches: leave via a failing press
    push(0, 0); push(2, 0);
    press_release(0);
    chk("none_busy_off", int'(busy), 0);
`endif
    chk("tmo_q_empty", expq.size(), 0);

    // reset mid-round at idx 2
    mem[0] = 2'd0; mem[1] = 2'd1; mem[2] = 2'd2;
    do_start(4'd3);
    push(0, 0); press_release(0);
    push(0, 1); press_release(1);
    chk("mid_idx2", int'(seq_idx), 2);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("mid_busy", int'(busy), 0);
    chk("mid_seq_idx", int'(seq_idx), 0);
    tick(20);
    chk("mid_q_empty", expq.size(), 0);

    // start while busy is ignored; latched length 1 stays
    mem[0] = 2'd0; mem[1] = 2'd1;
    do_start(4'd1);
    tick(2);
    round_len = 4'd5;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("ign_busy", int'(busy), 1);
    chk("ign_idx", int'(seq_idx), 0);
    push(0, 0); press_release(0);
    push(0, 1); push(1, 0); press_release(1);
    chk("ign_busy_off", int'(busy), 0);
    chk("ign_q_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
